// File: rtl/jtopl_eg_env.sv
// Time-multiplexed ADSR envelope generator: one slot per cen, attenuation 0 = loudest.
// Latency: 1 clk from a cen=1 cycle to eg_pure_out/eg_slot/eg_valid.
// No backpressure: cen paces the slot walk; outputs are a 1-cycle strobe per processed slot.
module jtopl_eg_env #(
  parameter int NUM_SLOTS = 18,
  parameter int SLOT_W    = 5,
  parameter int CNT_W     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  output logic [SLOT_W-1:0] slot,
  input  logic              keyon,
  input  logic [3:0]        ar,
  input  logic [3:0]        dr,
  input  logic [3:0]        rr,
  input  logic [3:0]        sl,
  input  logic              eg_type,
  input  logic              ksr,
  input  logic [3:0]        keycode,
  output logic [9:0]        eg_pure_out,
  output logic [SLOT_W-1:0] eg_slot,
  output logic              eg_valid
);

  typedef enum logic [1:0] {
    ST_ATTACK  = 2'd0,
    ST_DECAY   = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } eg_state_t;

  // Per-slot envelope context, addressed by the running slot index
  eg_state_t            state_q [NUM_SLOTS];
  logic [9:0]           attn_q  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] prev_keyon_q;
  logic [CNT_W-1:0]     eg_cnt;

  // Combinational view of the slot currently on the bus
  eg_state_t        cur_state;
  eg_state_t        eff_state;
  eg_state_t        next_state;
  logic [9:0]       cur_attn;
  logic [9:0]       next_attn;
  logic [9:0]       attack_attn;
  logic [9:0]       add_attn;
  logic [9:0]       stepped_attn;
  logic [9:0]       sl_att;
  logic             cur_pk;
  logic             key_on_edge;
  logic             key_off_edge;
  logic [3:0]       rate_reg;
  logic [3:0]       kc_add;
  logic [6:0]       rate_sum;
  logic [5:0]       rate;
  logic [3:0]       rh;
  logic [3:0]       sh;
  logic [CNT_W-1:0] cnt_mask;
  logic             step;
  logic [4:0]       inc;
  logic [11:0]      dec;
  logic [11:0]      attn_ext;
  logic [10:0]      attn_sum;
  logic             last_slot;

  assign last_slot = (slot == SLOT_W'(NUM_SLOTS - 1));

  // Rate, step and attenuation arithmetic for the current slot
  always_comb begin
    cur_state    = state_q[slot];
    cur_attn     = attn_q[slot];
    cur_pk       = prev_keyon_q[slot];
    key_on_edge  = keyon & ~cur_pk;
    key_off_edge = ~keyon & cur_pk;

    // A fresh key-on evaluates its step with the attack rate straight away
    eff_state = key_on_edge ? ST_ATTACK : cur_state;

    rate_reg = 4'd0;
    case (eff_state)
      ST_ATTACK:  rate_reg = ar;
      ST_DECAY:   rate_reg = dr;
      ST_SUSTAIN: rate_reg = eg_type ? 4'd0 : rr;
      ST_RELEASE: rate_reg = rr;
      default:    rate_reg = 4'd0;
    endcase

    kc_add   = ksr ? keycode : {2'b00, keycode[3:2]};
    rate_sum = {1'b0, rate_reg, 2'b00} + {3'b000, kc_add};
    if (rate_reg == 4'd0) begin
      rate = 6'd0;
    end else if (rate_sum > 7'd63) begin
      rate = 6'd63;
    end else begin
      rate = rate_sum[5:0];
    end

    // Slow rates step on a power-of-two frame period; fast rates step every frame with a larger increment
    rh       = rate[5:2];
    sh       = 4'd11 - rh;
    cnt_mask = (CNT_W'(1) << sh) - CNT_W'(1);
    if (rate == 6'd0) begin
      step = 1'b0;
    end else if (rh >= 4'd12) begin
      step = 1'b1;
    end else begin
      step = ((eg_cnt & cnt_mask) == '0);
    end
    inc = (rh >= 4'd12) ? (5'd1 << (rh - 4'd11)) : 5'd1;

    // Attack is exponential towards 0, other phases are linear towards 3FF
    dec         = ({5'd0, cur_attn[9:3]} + 12'd1) * {7'd0, inc};
    attn_ext    = {2'b00, cur_attn};
    attack_attn = (dec >= attn_ext) ? 10'd0 : (cur_attn - dec[9:0]);
    attn_sum    = {1'b0, cur_attn} + {6'd0, inc};
    add_attn    = attn_sum[10] ? 10'h3FF : attn_sum[9:0];

    stepped_attn = (eff_state == ST_ATTACK) ? attack_attn : add_attn;
    sl_att       = (sl == 4'd15) ? 10'h3E0 : {1'b0, sl, 5'b0};
  end

  // Next-state and next-attenuation selection, key events take priority
  always_comb begin
    next_state = cur_state;
    next_attn  = cur_attn;
    if (key_on_edge) begin
      next_state = ST_ATTACK;
      if (rate >= 6'd60) begin
        next_attn  = 10'd0;
        next_state = ST_DECAY;
      end else if (step) begin
        next_attn = stepped_attn;
      end
    end else if (key_off_edge) begin
      // Release starts from the level held at key-off; no step this cycle
      next_state = ST_RELEASE;
    end else begin
      if (step) begin
        next_attn = stepped_attn;
      end
      if (cur_state == ST_ATTACK && next_attn == 10'd0) begin
        next_state = ST_DECAY;
      end else if (cur_state == ST_DECAY && next_attn >= sl_att) begin
        next_state = ST_SUSTAIN;
      end
    end
  end

  // Per-slot state, attenuation and key-on history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= ST_RELEASE;
        attn_q[i]  <= 10'h3FF;
      end
      prev_keyon_q <= '0;
    end else if (cen) begin
      state_q[slot]      <= next_state;
      attn_q[slot]       <= next_attn;
      prev_keyon_q[slot] <= keyon;
    end
  end

  // Slot walk, frame counter and output strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot        <= '0;
      eg_cnt      <= '0;
      eg_pure_out <= 10'h3FF;
      eg_slot     <= '0;
      eg_valid    <= 1'b0;
    end else begin
      eg_valid <= 1'b0;
      if (cen) begin
        slot        <= last_slot ? '0 : slot + 1'b1;
        if (last_slot) begin
          eg_cnt <= eg_cnt + 1'b1;
        end
        eg_pure_out <= next_attn;
        eg_slot     <= slot;
        eg_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtopl_eg_env.sv
// Bench for jtopl_eg_env: per-slot register file tables, arithmetic envelope model, per-cycle compare.
// Latency: outputs compared 1 ns after each rising edge against the model's post-edge expectation.
// No backpressure: stimulus issues cen pulses directly; all waits are fixed cycle counts.
module tb_jtopl_eg_env;
  localparam int NS = 18;
  localparam int M_ATT = 0, M_DEC = 1, M_SUS = 2, M_REL = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic [4:0] slot;
  logic       keyon;
  logic [3:0] ar, dr, rr, sl;
  logic       eg_type, ksr;
  logic [3:0] keycode;
  logic [9:0] eg_pure_out;
  logic [4:0] eg_slot;
  logic       eg_valid;

  jtopl_eg_env #(.NUM_SLOTS(NS), .SLOT_W(5), .CNT_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .slot(slot), .keyon(keyon),
    .ar(ar), .dr(dr), .rr(rr), .sl(sl), .eg_type(eg_type), .ksr(ksr),
    .keycode(keycode), .eg_pure_out(eg_pure_out), .eg_slot(eg_slot), .eg_valid(eg_valid)
  );

  always #5 clk = ~clk;

  // Register-file contents per slot
  int p_kon[NS], p_ar[NS], p_dr[NS], p_rr[NS], p_sl[NS], p_eg[NS], p_ksr[NS], p_kc[NS];
  // Envelope model
  int m_st[NS], m_at[NS], m_pk[NS];
  int m_slot, m_cnt;
  int exp_out, exp_eg_slot, exp_slot, exp_valid;
  int last_out[NS];
  bit chk_en;
  int checks, failures;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int rate_of(input int r, input int k, input int kc);
    int v;
    if (r == 0) return 0;
    v = r * 4 + (k != 0 ? kc : kc / 4);
    return (v > 63) ? 63 : v;
  endfunction

  // Attenuation after one envelope tick at the given rate (unchanged if no step is due)
  function automatic int after_step(input bit atk, input int a, input int rate, input int cnt);
    int rh, inc, n;
    if (rate == 0) return a;
    rh = rate / 4;
    if (rh < 12) begin
      if ((cnt % (1 << (11 - rh))) != 0) return a;
      inc = 1;
    end else begin
      inc = 1 << (rh - 11);
    end
    if (atk) begin
      n = a - (a / 8 + 1) * inc;
      return (n < 0) ? 0 : n;
    end
    n = a + inc;
    return (n > 1023) ? 1023 : n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_st[i] = M_REL; m_at[i] = 1023; m_pk[i] = 0;
    end
    m_slot = 0; m_cnt = 0;
    exp_valid = 0; exp_out = 1023; exp_eg_slot = 0; exp_slot = 0;
  endtask

  task automatic model_step();
    int s, kon, r, reg_v, slatt;
    s = m_slot;
    kon = p_kon[s];
    if (kon != 0 && m_pk[s] == 0) begin
      r = rate_of(p_ar[s], p_ksr[s], p_kc[s]);
      m_st[s] = M_ATT;
      if (r >= 60) begin
        m_at[s] = 0; m_st[s] = M_DEC;
      end else begin
        m_at[s] = after_step(1'b1, m_at[s], r, m_cnt);
      end
    end else if (kon == 0 && m_pk[s] != 0) begin
      m_st[s] = M_REL;
    end else begin
      case (m_st[s])
        M_ATT:   reg_v = p_ar[s];
        M_DEC:   reg_v = p_dr[s];
        M_SUS:   reg_v = (p_eg[s] != 0) ? 0 : p_rr[s];
        default: reg_v = p_rr[s];
      endcase
      r = rate_of(reg_v, p_ksr[s], p_kc[s]);
      m_at[s] = after_step(m_st[s] == M_ATT, m_at[s], r, m_cnt);
      slatt = (p_sl[s] == 15) ? 992 : p_sl[s] * 32;
      if (m_st[s] == M_ATT && m_at[s] == 0) m_st[s] = M_DEC;
      else if (m_st[s] == M_DEC && m_at[s] >= slatt) m_st[s] = M_SUS;
    end
    m_pk[s] = kon;
    exp_out = m_at[s]; exp_eg_slot = s; exp_valid = 1;
    if (s == NS - 1) begin
      m_slot = 0; m_cnt = (m_cnt + 1) % 32768;
    end else begin
      m_slot = s + 1;
    end
    exp_slot = m_slot;
  endtask

  // One clock: present the model slot's registers, advance model, capture output 2 ns after the edge
  task automatic cycle(input bit c);
    int s;
    s = m_slot;
    cen     = c;
    keyon   = (p_kon[s] != 0);
    ar      = 4'(p_ar[s]);
    dr      = 4'(p_dr[s]);
    rr      = 4'(p_rr[s]);
    sl      = 4'(p_sl[s]);
    eg_type = (p_eg[s] != 0);
    ksr     = (p_ksr[s] != 0);
    keycode = 4'(p_kc[s]);
    if (c) model_step();
    else exp_valid = 0;
    @(posedge clk);
    #2;
    if (c) last_out[s] = int'(eg_pure_out);
    cen = 1'b0;
  endtask

  task automatic run_frames(input int n);
    repeat (n * NS) cycle(1'b1);
  endtask

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("eg_valid", int'(eg_valid), exp_valid);
      check("slot", int'(slot), exp_slot);
      check("eg_pure_out", int'(eg_pure_out), exp_out);
      check("eg_slot", int'(eg_slot), exp_eg_slot);
    end
  end

  initial begin
    checks = 0; failures = 0; chk_en = 1'b0;
    for (int i = 0; i < NS; i++) begin
      p_kon[i] = 0; p_ar[i] = 0; p_dr[i] = 0; p_rr[i] = 0;
      p_sl[i] = 0; p_eg[i] = 0; p_ksr[i] = 0; p_kc[i] = 0; last_out[i] = -1;
    end
    cen = 0; keyon = 0; ar = 0; dr = 0; rr = 0; sl = 0;
    eg_type = 0; ksr = 0; keycode = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check("reset_slot", int'(slot), 0);
    check("reset_valid", int'(eg_valid), 0);
    check("reset_out", int'(eg_pure_out), 1023);
    check("reset_eg_slot", int'(eg_slot), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk_en = 1'b1;

    // Idle frame: every slot silent, then wrap
    repeat (NS) cycle(1'b1);
    check("idle_wrap_slot", int'(slot), 0);
    check("idle_last_eg_slot", int'(eg_slot), 17);
    check("idle_slot17_out", last_out[17], 1023);

    // Slot 0: instant attack, decay to sl=1, hold
    p_kon[0] = 1; p_ar[0] = 15; p_dr[0] = 15; p_sl[0] = 1; p_eg[0] = 1; p_rr[0] = 15;
    run_frames(1); check("ar15_instant", last_out[0], 0);
    run_frames(1); check("decay_1", last_out[0], 16);
    run_frames(1); check("decay_2", last_out[0], 32);
    run_frames(1); check("sustain_hold", last_out[0], 32);

    // Slot 0 key-off and release to saturation
    p_kon[0] = 0;
    run_frames(1); check("keyoff_frame", last_out[0], 32);
    run_frames(1); check("release_1", last_out[0], 48);
    run_frames(1); check("release_2", last_out[0], 64);
    run_frames(59); check("release_61", last_out[0], 1008);
    run_frames(1); check("release_sat", last_out[0], 1023);
    run_frames(1); check("release_sat_hold", last_out[0], 1023);

    // Exponential attacks, ar=0 stall, slow rates, decaying sustain
    p_kon[1] = 1; p_ar[1] = 12;
    p_kon[2] = 1; p_ar[2] = 12;
    p_kon[3] = 1; p_ar[3] = 0;
    p_kon[4] = 1; p_ar[4] = 8; p_kc[4] = 7;
    p_kon[5] = 1; p_ar[5] = 4; p_ksr[5] = 1; p_kc[5] = 5;
    p_kon[6] = 1; p_ar[6] = 15; p_dr[6] = 13; p_sl[6] = 2; p_rr[6] = 10;
    run_frames(1); check("attack_1", last_out[1], 767); check("attack_1b", last_out[2], 767);
    run_frames(1); check("attack_2", last_out[1], 575);
    run_frames(1); check("attack_3", last_out[1], 431);
    p_kon[1] = 0; p_rr[1] = 12;
    run_frames(1); check("midattack_keyoff", last_out[1], 431);
    run_frames(1); check("midattack_rel_1", last_out[1], 433);
    run_frames(1); check("midattack_rel_2", last_out[1], 435);
    run_frames(22);
    check("attack_to_zero", last_out[2], 0);
    check("ar0_stuck", last_out[3], 1023);

    // cen held low mid-frame: everything frozen
    repeat (5) cycle(1'b1);
    repeat (10) cycle(1'b0);
    check("cen_low_valid", int'(eg_valid), 0);
    repeat (13) cycle(1'b1);

    // Asynchronous reset between clock edges
    repeat (7) cycle(1'b1);
    chk_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_slot", int'(slot), 0);
    check("async_rst_valid", int'(eg_valid), 0);
    check("async_rst_out", int'(eg_pure_out), 1023);
    check("async_rst_eg_slot", int'(eg_slot), 0);
    for (int i = 0; i < NS; i++) p_kon[i] = 0;
    model_reset();
    #2;
    rst_n = 1'b1;
    chk_en = 1'b1;
    run_frames(2);
    check("post_rst_slot6", last_out[6], 1023);
    check("post_rst_slot2", last_out[2], 1023);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
